// File: rtl/memory_if.sv
// ============================================================================
// Module      : memory_if
// Description : Request/response bus for the single-port RAM. The requester
//               drives en/op/addr/datain; the RAM returns ready/status/dataout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_if #(
  parameter int WORDSIZE          = 8,
  parameter int MEMORY_ADDR_WIDTH = 8
);
  logic                         en;
  logic                         op;
  logic [WORDSIZE-1:0]          addr;
  logic [MEMORY_ADDR_WIDTH-1:0] datain;
  logic [MEMORY_ADDR_WIDTH-1:0] dataout;
  logic [1:0]                   status;
  logic                         ready;

  modport master (
    output en, op, addr, datain,
    input  dataout, status, ready
  );

  modport slave (
    input  en, op, addr, datain,
    output dataout, status, ready
  );
endinterface

`default_nettype wire

// File: rtl/memory.sv
// ============================================================================
// Module      : memory
// Description : Single-port synchronous RAM with an en/ready handshake.
//               IDLE -> BUSY latches the request, BUSY -> DONE performs the
//               access and raises ready, DONE -> IDLE once en drops.
//               Optional macro MEMORY_CLEAR_ON_RESET_EN: when defined, reset
//               also clears every stored word to 0; otherwise contents
//               survive reset.
//               The bus interface must be instantiated with the same
//               WORDSIZE / MEMORY_ADDR_WIDTH as this module.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory #(
  parameter int WORDSIZE          = 8,
  parameter int MEMORY_ADDR_WIDTH = 8,
  parameter int NUMBER_OF_WORDS   = 256
) (
  input  logic      clk,
  input  logic      reset,
  memory_if.slave   bus
);

  localparam int IDX_W = (NUMBER_OF_WORDS > 1) ? $clog2(NUMBER_OF_WORDS) : 1;
  // One bit wider than addr so that NUMBER_OF_WORDS == 2**WORDSIZE still fits.
  localparam logic [WORDSIZE:0] WORDS_LIMIT = (WORDSIZE + 1)'(NUMBER_OF_WORDS);

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_WR_OK = 2'b01;
  localparam logic [1:0] ST_RD_OK = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;

  logic                         op_q;
  logic [WORDSIZE-1:0]          addr_q;
  logic [MEMORY_ADDR_WIDTH-1:0] data_q;

  logic                         ready_nxt;
  logic [1:0]                   status_nxt;
  logic [MEMORY_ADDR_WIDTH-1:0] dataout_nxt;
  logic                         latch_req;
  logic                         mem_we;
  logic                         addr_err;
  logic [IDX_W-1:0]             idx;

  logic [MEMORY_ADDR_WIDTH-1:0] mem [NUMBER_OF_WORDS];

  assign idx      = addr_q[IDX_W-1:0];
  assign addr_err = ({1'b0, addr_q} >= WORDS_LIMIT);

  // Next-state and next-output decode; everything holds unless a state acts.
  always_comb begin
    state_nxt   = state;
    ready_nxt   = bus.ready;
    status_nxt  = bus.status;
    dataout_nxt = bus.dataout;
    latch_req   = 1'b0;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) begin
          state_nxt  = BUSY;
          latch_req  = 1'b1;
          status_nxt = ST_NONE;
        end
      end
      BUSY: begin
        // en is not consulted here: once accepted, an operation always completes.
        state_nxt = DONE;
        ready_nxt = 1'b1;
        if (addr_err) begin
          status_nxt = ST_ERR;
        end else if (op_q) begin
          mem_we     = 1'b1;
          status_nxt = ST_WR_OK;
        end else begin
          status_nxt  = ST_RD_OK;
          dataout_nxt = mem[idx];
        end
      end
      DONE: begin
        if (!bus.en) begin
          state_nxt = IDLE;
          ready_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b0;
      end
    endcase
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bus.ready   <= 1'b0;
      bus.status  <= ST_NONE;
      bus.dataout <= '0;
    end else begin
      state       <= state_nxt;
      bus.ready   <= ready_nxt;
      bus.status  <= status_nxt;
      bus.dataout <= dataout_nxt;
    end
  end

  // Request capture; later changes on op/addr/datain are ignored until IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (latch_req) begin
      op_q   <= bus.op;
      addr_q <= bus.addr;
      data_q <= bus.datain;
    end
  end

`ifdef MEMORY_CLEAR_ON_RESET_EN
  // Storage array, cleared to zero by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUMBER_OF_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[idx] <= data_q;
    end
  end
`else
  // Storage array, contents retained across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= data_q;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory.sv
// ============================================================================
// Module      : tb_memory
// Description : Self-checking bench for memory. A transaction-level model
//               (word array + known flags) predicts ready/status/dataout; a
//               compare process checks them every cycle on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory;

  localparam int WS = 8;
  localparam int DW = 8;
  localparam int NW = 16;

`ifdef MEMORY_CLEAR_ON_RESET_EN
  localparam logic [DW-1:0] W08_AFTER_RST = 8'h00;
  localparam logic [DW-1:0] W0A_AFTER_ABORT = 8'h00;
`else
  localparam logic [DW-1:0] W08_AFTER_RST = 8'hF0;
  localparam logic [DW-1:0] W0A_AFTER_ABORT = 8'h33;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  memory_if #(.WORDSIZE(WS), .MEMORY_ADDR_WIDTH(DW)) bus ();

  memory #(
    .WORDSIZE(WS),
    .MEMORY_ADDR_WIDTH(DW),
    .NUMBER_OF_WORDS(NW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Model state
  logic [DW-1:0] m_mem [NW];
  bit            m_known [NW];
  logic          exp_ready;
  logic [1:0]    exp_status;
  logic [DW-1:0] exp_dout;
  bit            exp_dout_known;
  bit            chk_on;

  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("ready", 32'(bus.ready), 32'(exp_ready));
      check("status", 32'(bus.status), 32'(exp_status));
      if (exp_dout_known) check("dataout", 32'(bus.dataout), 32'(exp_dout));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_ready      = 1'b0;
    exp_status     = 2'b00;
    exp_dout       = '0;
    exp_dout_known = 1'b1;
`ifdef MEMORY_CLEAR_ON_RESET_EN
    for (int i = 0; i < NW; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b1;
    end
`endif
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // One full transaction; called with the DUT idle, just after a rising edge.
  task automatic do_op(input bit wr, input int a, input logic [DW-1:0] d,
                       input int hold, input bit scramble, input bit early, input bit abort);
    bit err;
    err        = (a >= NW);
    bus.en     = 1'b1;
    bus.op     = wr;
    bus.addr   = WS'(a);
    bus.datain = d;
    tick();                       // request accepted
    exp_ready  = 1'b0;
    exp_status = 2'b00;
    if (scramble) begin
      bus.op     = ~wr;
      bus.addr   = WS'($urandom);
      bus.datain = DW'($urandom);
    end
    if (abort) begin
      reset = 1'b0;
      model_reset();
      #1;
      check("abort_ready", 32'(bus.ready), 32'd0);
      check("abort_status", 32'(bus.status), 32'd0);
      check("abort_dataout", 32'(bus.dataout), 32'd0);
      bus.en = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      return;
    end
    if (early) bus.en = 1'b0;
    tick();                       // access performed
    exp_ready = 1'b1;
    if (err) begin
      exp_status = 2'b11;
    end else if (wr) begin
      exp_status = 2'b01;
      m_mem[a]   = d;
      m_known[a] = 1'b1;
    end else begin
      exp_status     = 2'b10;
      exp_dout       = m_mem[a];
      exp_dout_known = m_known[a];
    end
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        if (scramble) begin
          bus.addr   = WS'($urandom);
          bus.datain = DW'($urandom);
        end
        tick();
      end
    end
    bus.en = 1'b0;
    tick();                       // back to idle
    exp_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_on      = 1'b0;
    bus.en      = 1'b0;
    bus.op      = 1'b0;
    bus.addr    = '0;
    bus.datain  = '0;
    for (int i = 0; i < NW; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_status", 32'(bus.status), 32'd0);
    check("rst_dataout", 32'(bus.dataout), 32'd0);
    chk_on = 1'b1;
    reset  = 1'b1;
    tick();

    // Write F0 to 0x08
    do_op(1'b1, 8'h08, 8'hF0, 1, 1'b0, 1'b0, 1'b0);
    check("w08_status", 32'(bus.status), 32'd1);
    check("w08_ready_low", 32'(bus.ready), 32'd0);

    // Reset, then read 0x08
    pulse_reset();
    do_op(1'b0, 8'h08, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    check("r08_dataout", 32'(bus.dataout), 32'(W08_AFTER_RST));
    check("r08_status", 32'(bus.status), 32'd2);

    // Write F1 to 0x09, read back, 0x08 untouched
    do_op(1'b1, 8'h09, 8'hF1, 2, 1'b1, 1'b0, 1'b0);
    do_op(1'b0, 8'h09, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    check("r09_dataout", 32'(bus.dataout), 32'hF1);
    check("r09_status", 32'(bus.status), 32'd2);
    do_op(1'b0, 8'h08, 8'h00, 0, 1'b0, 1'b1, 1'b0);
    check("r08b_dataout", 32'(bus.dataout), 32'(W08_AFTER_RST));

    // Write 33 to 0x0A, abort a write of AA, read back
    do_op(1'b1, 8'h0A, 8'h33, 0, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 8'h0A, 8'hAA, 0, 1'b0, 1'b0, 1'b1);
    do_op(1'b0, 8'h0A, 8'h00, 1, 1'b0, 1'b0, 1'b0);
    check("r0A_dataout", 32'(bus.dataout), 32'(W0A_AFTER_ABORT));

    // Out-of-range write leaves storage and dataout alone
    do_op(1'b1, 8'h04, 8'h44, 0, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 20, 8'h99, 1, 1'b0, 1'b0, 1'b0);
    check("oor_status", 32'(bus.status), 32'd3);
    check("oor_dataout", 32'(bus.dataout), 32'(W0A_AFTER_ABORT));
    do_op(1'b0, 8'h04, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    check("r04_dataout", 32'(bus.dataout), 32'h44);
    // Out-of-range read: status error, dataout unchanged
    do_op(1'b0, 8'hFF, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    check("oor_rd_status", 32'(bus.status), 32'd3);
    check("oor_rd_dataout", 32'(bus.dataout), 32'h44);

`ifdef MEMORY_CLEAR_ON_RESET_EN
    do_op(1'b1, 8'h03, 8'h55, 0, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    do_op(1'b0, 8'h03, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    check("clr_dataout", 32'(bus.dataout), 32'h00);
    check("clr_status", 32'(bus.status), 32'd2);
`endif

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      do_op(1'($urandom_range(0, 1)),
            int'($urandom_range(0, NW + 7)),
            DW'($urandom),
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 19) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
